// File: rtl/synapse_pkg.sv
// Shared types and default sizing for the synapse scheduler and its accumulator.
package synapse_pkg;

  localparam int unsigned N_PRE_DEF  = 8;
  localparam int unsigned W_DW_DEF   = 16;
  localparam int unsigned ACC_DW_DEF = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Address width, kept at least one bit so a single-input build still has a port.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/synapse_acc.sv
// Signed accumulator with sticky overflow flag.
// SYN_SAT_EN selects saturation on overflow; otherwise the sum wraps two's-complement.
module synapse_acc
  import synapse_pkg::*;
#(
  parameter int unsigned W_DW   = W_DW_DEF,
  parameter int unsigned ACC_DW = ACC_DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     add_i,
  input  logic signed [W_DW-1:0]   prod_i,
  output logic signed [ACC_DW-1:0] acc_o,
  output logic                     ovf_o
);

  localparam int unsigned SW = ACC_DW + 1;

  logic signed [ACC_DW-1:0] acc_q, acc_d;
  logic                     ovf_q;
  logic signed [SW-1:0]     sum_c;
  logic                     ovf_c;

  // One guard bit: overflow when the two top bits of the widened sum disagree.
  always_comb begin
    sum_c = {acc_q[ACC_DW-1], acc_q} + {{(SW-W_DW){prod_i[W_DW-1]}}, prod_i};
    ovf_c = sum_c[SW-1] ^ sum_c[SW-2];
    acc_d = sum_c[ACC_DW-1:0];
`ifdef SYN_SAT_EN
    if (ovf_c) begin
      acc_d = sum_c[SW-1] ? {1'b1, {(ACC_DW-1){1'b0}}} : {1'b0, {(ACC_DW-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      if (clr_i) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (add_i) begin
        acc_q <= acc_d;
        ovf_q <= ovf_q | ovf_c;
      end
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/synapse_scheduler.sv
// Scans a snapshotted spike vector, fetches one weight per input and sums the
// weights of spiking inputs through a two-stage product/accumulate pipeline.
module synapse_scheduler
  import synapse_pkg::*;
#(
  parameter int unsigned N_PRE  = N_PRE_DEF,
  parameter int unsigned W_DW   = W_DW_DEF,
  parameter int unsigned ACC_DW = ACC_DW_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [N_PRE-1:0]             pre_spikes,
  output logic                         w_rd_en,
  output logic [addr_w(N_PRE)-1:0]     w_addr,
  input  logic signed [W_DW-1:0]       w_data,
  output logic                         busy,
  output logic                         done,
  output logic signed [ACC_DW-1:0]     sum_out,
  output logic                         ovf
);

  localparam int unsigned AW = addr_w(N_PRE);

  state_e                   state_q;
  logic [N_PRE-1:0]         snap_q;
  logic [AW-1:0]            addr_q;
  logic [AW-1:0]            ret_addr_q;
  logic                     rd_en_q;
  logic                     v1_q;
  logic                     v2_q;
  logic signed [W_DW-1:0]   prod_q;
  logic                     busy_q;
  logic                     done_q;
  logic signed [ACC_DW-1:0] sum_q;
  logic                     ovf_q;

  logic signed [ACC_DW-1:0] acc_val;
  logic                     acc_ovf;
  logic                     acc_clr_c;

  assign acc_clr_c = (state_q == S_IDLE) && start;

  // v1_q: weight returning this cycle; v2_q: product register holds a live term.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      snap_q     <= '0;
      addr_q     <= '0;
      ret_addr_q <= '0;
      rd_en_q    <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      prod_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= v1_q;
      if (v1_q) begin
        prod_q <= snap_q[ret_addr_q] ? w_data : '0;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ISSUE;
            snap_q  <= pre_spikes;
            addr_q  <= '0;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          v1_q       <= 1'b1;
          ret_addr_q <= addr_q;
          if (addr_q == AW'(N_PRE - 1)) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        S_DRAIN: begin
          // Last product is being accumulated on this edge.
          if (v2_q && !v1_q) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          sum_q   <= acc_val;
          ovf_q   <= acc_ovf;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  synapse_acc #(
    .W_DW   (W_DW),
    .ACC_DW (ACC_DW)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .clr_i  (acc_clr_c),
    .add_i  (v2_q),
    .prod_i (prod_q),
    .acc_o  (acc_val),
    .ovf_o  (acc_ovf)
  );

  // Strobes are masked by en so a stall neither reads memory nor drops a held done.
  assign w_rd_en = rd_en_q & en;
  assign done    = done_q & en;
  assign w_addr  = addr_q;
  assign busy    = busy_q;
  assign sum_out = sum_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_synapse_scheduler.sv
// Directed bench: two scheduler instances (24-bit and 16-bit accumulators) share stimulus.
module tb_synapse_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, start;
  logic [3:0]        pre_spikes;
  logic signed [15:0] mem [4];

  logic              rd_a, rd_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [1:0]        addr_a, addr_b;
  logic signed [15:0] wd_a, wd_b;
  logic signed [23:0] sum_a;
  logic signed [15:0] sum_b;

  synapse_scheduler #(.N_PRE(4), .W_DW(16), .ACC_DW(24)) dut_a (
    .clk(clk), .rst(rst), .en(en), .start(start), .pre_spikes(pre_spikes),
    .w_rd_en(rd_a), .w_addr(addr_a), .w_data(wd_a), .busy(busy_a),
    .done(done_a), .sum_out(sum_a), .ovf(ovf_a)
  );

  synapse_scheduler #(.N_PRE(4), .W_DW(16), .ACC_DW(16)) dut_b (
    .clk(clk), .rst(rst), .en(en), .start(start), .pre_spikes(pre_spikes),
    .w_rd_en(rd_b), .w_addr(addr_b), .w_data(wd_b), .busy(busy_b),
    .done(done_b), .sum_out(sum_b), .ovf(ovf_b)
  );

  // One-cycle-latency weight memories.
  always @(posedge clk) begin
    if (rst) begin
      wd_a <= '0;
      wd_b <= '0;
    end else begin
      if (rd_a) wd_a <= mem[addr_a];
      if (rd_b) wd_b <= mem[addr_b];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int lat, ndone;
  logic busy1, rd_stall;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Called #1 after a rising edge; the next edge (E0) accepts start.
  task automatic run_eval(input logic [3:0] spk, input int stall_at, input bit disturb,
                          input int rst_at);
    pre_spikes = spk;
    start      = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = -1;
    ndone    = 0;
    busy1    = 1'b0;
    rd_stall = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done_a) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (k == 1) busy1 = busy_a;
      if (stall_at > 0 && k == stall_at + 1) rd_stall = rd_a;
      if (k == stall_at) en = 1'b0;
      if (k == stall_at + 3) en = 1'b1;
      if (disturb && k == 2) begin
        start      = 1'b1;
        pre_spikes = 4'b1111;
      end
      if (disturb && k == 3) start = 1'b0;
      if (k == rst_at) rst = 1'b1;
      if (k == rst_at + 1) rst = 1'b0;
    end
  endtask

  initial begin
    mem[0] = 16'sd100; mem[1] = -16'sd50; mem[2] = 16'sd200; mem[3] = 16'sd7;
    rst = 1'b1; en = 1'b1; start = 1'b0; pre_spikes = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_sum", sum_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rden", rd_a, 0);
    check("rst_addr", addr_a, 0);

    run_eval(4'b0101, 0, 1'b0, 0);
    check("basic_lat", lat, 7);
    check("basic_ndone", ndone, 1);
    check("basic_sum", sum_a, 300);
    check("basic_ovf", ovf_a, 0);
    check("basic_busy", busy1, 1);

    run_eval(4'b0101, 2, 1'b0, 0);
    check("stall_lat", lat, 10);
    check("stall_ndone", ndone, 1);
    check("stall_sum", sum_a, 300);
    check("stall_rden", rd_stall, 0);

    run_eval(4'b0101, 0, 1'b1, 0);
    check("busy_lat", lat, 7);
    check("busy_ndone", ndone, 1);
    check("busy_sum", sum_a, 300);

    run_eval(4'b0101, 0, 1'b0, 3);
    check("rstmid_ndone", ndone, 0);
    check("rstmid_sum", sum_a, 0);
    check("rstmid_ovf", ovf_a, 0);
    check("rstmid_busy", busy_a, 0);
    run_eval(4'b1000, 0, 1'b0, 0);
    check("fresh_lat", lat, 7);
    check("fresh_sum", sum_a, 7);

    for (int i = 0; i < 4; i++) mem[i] = 16'sd32767;
    run_eval(4'b1111, 0, 1'b0, 0);
`ifdef SYN_SAT_EN
    check("ovf16_sum", sum_b, 32767);
`else
    check("ovf16_sum", sum_b, -4);
`endif
    check("ovf16_flag", ovf_b, 1);
    check("ovf24_sum", sum_a, 131068);
    check("ovf24_flag", ovf_a, 0);

    run_eval(4'b0000, 0, 1'b0, 0);
    check("empty_lat", lat, 7);
    check("empty_sum", sum_a, 0);
    check("empty_ovf", ovf_a, 0);
    check("empty_sum16", sum_b, 0);
    check("empty_ovf16", ovf_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
